// File: rtl/ibex_fetch_req_gen.sv
// ibex_fetch_req_gen: IF-stage instruction bus requester feeding the fetch FIFO; IBEX_FETCH_PERF_EN adds perf counters
module ibex_fetch_req_gen #(
   parameter int NUM_REQS = 2,
   parameter bit ResetAll = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic                branch_i,
   input  logic [31:0]         addr_i,
   output logic                busy_o,
   input  logic [NUM_REQS-1:0] fifo_busy_i,
   output logic                fifo_clear_o,
   output logic                fifo_valid_o,
   output logic [31:0]         fifo_addr_o,
   output logic [31:0]         fifo_rdata_o,
   output logic                fifo_err_o,
   output logic                instr_req_o,
   input  logic                instr_gnt_i,
   output logic [31:0]         instr_addr_o,
   input  logic                instr_rvalid_i,
   input  logic [31:0]         instr_rdata_i,
   input  logic                instr_err_i,
   output logic [31:0]         perf_req_cnt_o,
   output logic [31:0]         perf_discard_cnt_o
);
   localparam int CW = $clog2(NUM_REQS + 1);

   logic [31:0]         fetch_addr_q, fetch_addr_d, branch_addr;
   logic [31:0]         addr_q [NUM_REQS];
   logic [31:0]         addr_d [NUM_REQS];
   logic [NUM_REQS-1:0] disc_q, disc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                req_held_q, room, push, pop, drop;
   int                  occ, wr_idx;

   always_comb begin
      occ = 0;
      for (int k = 0; k < NUM_REQS; k++) occ = occ + int'(fifo_busy_i[k]);
   end

   // a branch clears the FIFO this cycle, so its occupancy no longer limits issue
   assign room         = int'(cnt_q) + (branch_i ? 0 : occ) < NUM_REQS;
   assign instr_req_o  = req_held_q | (req_i & room);
   assign branch_addr  = {addr_i[31:2], 2'b00};
   assign instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
   assign push         = instr_req_o & instr_gnt_i;
   assign pop          = instr_rvalid_i & (cnt_q != '0);
   assign drop         = disc_q[0] | branch_i;
   assign fifo_clear_o = branch_i;
   assign fifo_valid_o = pop & ~drop;
   assign fifo_addr_o  = branch_i ? addr_i : addr_q[0];
   assign fifo_rdata_o = instr_rdata_i;
   assign fifo_err_o   = instr_err_i;
   assign busy_o       = instr_req_o | (cnt_q != '0);
   assign cnt_d        = cnt_q + CW'(push) - CW'(pop);
   assign fetch_addr_d = push ? instr_addr_o + 32'd4 : branch_i ? branch_addr : fetch_addr_q;

   always_comb begin
      addr_d = addr_q;
      disc_d = branch_i ? '1 : disc_q;
      wr_idx = int'(cnt_q) - int'(pop);
      if (pop) begin
         for (int k = 0; k < NUM_REQS - 1; k++) begin
            addr_d[k] = addr_d[k+1];
            disc_d[k] = disc_d[k+1];
         end
      end
      for (int k = 0; k < NUM_REQS; k++) begin
         if (push && k == wr_idx) begin
            addr_d[k] = instr_addr_o;
            disc_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         disc_q     <= '0;
         req_held_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         disc_q     <= disc_d;
         req_held_q <= instr_req_o & ~instr_gnt_i;
      end
   end

   if (ResetAll) begin : g_dp_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            fetch_addr_q <= '0;
            addr_q       <= '{default: '0};
         end else begin
            fetch_addr_q <= fetch_addr_d;
            addr_q       <= addr_d;
         end
      end
   end else begin : g_dp_nrst
      always_ff @(posedge clk_i) begin
         fetch_addr_q <= fetch_addr_d;
         addr_q       <= addr_d;
      end
   end

`ifdef IBEX_FETCH_PERF_EN
   logic [31:0] perf_req_q, perf_disc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_req_q  <= '0;
         perf_disc_q <= '0;
      end else begin
         if (push && perf_req_q != '1) perf_req_q <= perf_req_q + 32'd1;
         if (pop && drop && perf_disc_q != '1) perf_disc_q <= perf_disc_q + 32'd1;
      end
   end

   assign perf_req_cnt_o     = perf_req_q;
   assign perf_discard_cnt_o = perf_disc_q;
`else
   assign perf_req_cnt_o     = '0;
   assign perf_discard_cnt_o = '0;
`endif

   assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> cnt_q != '0);
   assert property (@(posedge clk_i) disable iff (!rst_ni) int'(cnt_q) <= NUM_REQS);

endmodule

// File: tb/tb_ibex_fetch_req_gen.sv
// tb_ibex_fetch_req_gen: scenario tasks against a scoreboard of expected FIFO writes
module tb_ibex_fetch_req_gen;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        req_i, branch_i, instr_gnt_i, instr_rvalid_i, instr_err_i;
   logic [31:0] addr_i, instr_rdata_i;
   logic [1:0]  fifo_busy_i;
   logic        busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o, instr_req_o;
   logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o, perf_req_cnt_o, perf_discard_cnt_o;

   typedef struct packed {logic [31:0] addr; logic [31:0] data; logic err;} wr_t;
   wr_t exp_q[$];
   int  checks = 0, errors = 0;

   always #5 clk_i = ~clk_i;

   ibex_fetch_req_gen #(.NUM_REQS(2), .ResetAll(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
      .busy_o(busy_o), .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
      .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
      .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
      .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .instr_err_i(instr_err_i), .perf_req_cnt_o(perf_req_cnt_o), .perf_discard_cnt_o(perf_discard_cnt_o)
   );

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic r, input logic b, input logic [31:0] a, input logic g);
      req_i = r; branch_i = b; addr_i = a; instr_gnt_i = g;
      instr_rvalid_i = 1'b0; instr_err_i = 1'b0; instr_rdata_i = '0;
   endtask

   task automatic resp(input logic [31:0] a, input logic keep, input logic e);
      instr_rvalid_i = 1'b1; instr_rdata_i = data_of(a); instr_err_i = e;
      if (keep) exp_q.push_back('{a, data_of(a), e});
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && fifo_valid_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL fifo_write unexpected got addr=%h", fifo_addr_o);
         end else if ({fifo_addr_o, fifo_rdata_o, fifo_err_o} !== exp_q[0]) begin
            errors++;
            $display("FAIL fifo_write got=%h/%h/%b exp=%h/%h/%b", fifo_addr_o, fifo_rdata_o, fifo_err_o,
                     exp_q[0].addr, exp_q[0].data, exp_q[0].err);
            void'(exp_q.pop_front());
         end else void'(exp_q.pop_front());
      end
   end

   task automatic test_reset();
      drive(0, 0, 0, 0); fifo_busy_i = 2'b00;
      @(negedge clk_i);
      checks++; if ({instr_req_o, busy_o, fifo_valid_o, fifo_clear_o} !== 4'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {instr_req_o, busy_o, fifo_valid_o, fifo_clear_o}); end
      checks++; if (instr_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", instr_addr_o); end
      checks++; if ({perf_req_cnt_o, perf_discard_cnt_o} !== 64'h0) begin errors++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_req_cnt_o, perf_discard_cnt_o); end
      cyc(); rst_ni = 1'b1;
   endtask

   task automatic test_stream();
      drive(1, 1, 32'h100, 1);
      @(negedge clk_i);
      checks++; if ({instr_req_o, fifo_clear_o, instr_addr_o} !== {2'b11, 32'h100}) begin errors++; $display("FAIL stream_branch got=%b%b/%h exp=11/00000100", instr_req_o, fifo_clear_o, instr_addr_o); end
      checks++; if (fifo_addr_o !== 32'h100) begin errors++; $display("FAIL stream_clear_addr got=%h exp=00000100", fifo_addr_o); end
      for (int i = 1; i < 3; i++) begin
         cyc(); drive(1, 0, 0, 1); resp(32'h100 + 32'(4 * (i - 1)), 1, 0);
         @(negedge clk_i);
         checks++; if ({instr_addr_o, fifo_valid_o} !== {32'h100 + 32'(4 * i), 1'b1}) begin errors++; $display("FAIL stream_addr%0d got=%h/%b exp=%h/1", i, instr_addr_o, fifo_valid_o, 32'h100 + 32'(4 * i)); end
      end
      cyc(); drive(0, 0, 0, 0); resp(32'h108, 1, 1);
      @(negedge clk_i);
      checks++; if ({instr_req_o, busy_o} !== 2'b01) begin errors++; $display("FAIL stream_last got=%b%b exp=01", instr_req_o, busy_o); end
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b exp=0", busy_o); end
      cyc();
   endtask

   task automatic test_limit();
      int g = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 1);
         @(negedge clk_i);
         if (instr_req_o === 1'b1) g++;
         cyc();
      end
      checks++; if (g != 2) begin errors++; $display("FAIL limit_grants got=%0d exp=2", g); end
      drive(1, 0, 0, 1); resp(32'h10C, 1, 0);
      @(negedge clk_i);
      checks++; if ({instr_req_o, busy_o} !== 2'b01) begin errors++; $display("FAIL limit_full got=%b%b exp=01", instr_req_o, busy_o); end
      cyc(); drive(1, 0, 0, 1); resp(32'h110, 1, 0);
      @(negedge clk_i);
      checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h114}) begin errors++; $display("FAIL limit_resume got=%b/%h exp=1/00000114", instr_req_o, instr_addr_o); end
      cyc(); drive(0, 0, 0, 0); resp(32'h114, 1, 0);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL limit_idle got=%b exp=0", busy_o); end
      cyc();
   endtask

   task automatic test_branch_discard();
      drive(1, 0, 0, 1); cyc();
      drive(1, 0, 0, 1); cyc();
      drive(1, 1, 32'h202, 0); resp(32'h118, 0, 0);
      @(negedge clk_i);
      checks++; if ({fifo_clear_o, instr_req_o, fifo_valid_o, instr_addr_o} !== {3'b100, 32'h200}) begin errors++; $display("FAIL br_cycle got=%b%b%b/%h exp=100/00000200", fifo_clear_o, instr_req_o, fifo_valid_o, instr_addr_o); end
      checks++; if (fifo_addr_o !== 32'h202) begin errors++; $display("FAIL br_fifo_addr got=%h exp=00000202", fifo_addr_o); end
      cyc(); drive(1, 0, 0, 1); resp(32'h11C, 0, 0);
      @(negedge clk_i);
      checks++; if ({instr_req_o, fifo_valid_o, instr_addr_o} !== {2'b10, 32'h200}) begin errors++; $display("FAIL br_stale got=%b%b/%h exp=10/00000200", instr_req_o, fifo_valid_o, instr_addr_o); end
      cyc(); drive(0, 0, 0, 0); resp(32'h200, 1, 0);
      @(negedge clk_i);
      checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL br_new_write got=%b exp=1", fifo_valid_o); end
`ifdef IBEX_FETCH_PERF_EN
      checks++; if ({perf_req_cnt_o, perf_discard_cnt_o} !== {32'd9, 32'd2}) begin errors++; $display("FAIL br_perf got=%0d/%0d exp=9/2", perf_req_cnt_o, perf_discard_cnt_o); end
`else
      checks++; if ({perf_req_cnt_o, perf_discard_cnt_o} !== 64'h0) begin errors++; $display("FAIL br_perf got=%0d/%0d exp=0/0", perf_req_cnt_o, perf_discard_cnt_o); end
`endif
      cyc();
   endtask

   task automatic test_hold();
      for (int i = 0; i < 4; i++) begin
         drive(i == 0, 0, 0, i == 3);
         @(negedge clk_i);
         checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h204}) begin errors++; $display("FAIL hold_c%0d got=%b/%h exp=1/00000204", i, instr_req_o, instr_addr_o); end
         cyc();
      end
      drive(0, 0, 0, 0); resp(32'h204, 1, 0);
      @(negedge clk_i);
      checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", instr_req_o); end
      cyc();
   endtask

   task automatic test_wrap();
      drive(1, 0, 0, 0); cyc();
      drive(0, 1, 32'hFFFF_FFFE, 0);
      @(negedge clk_i);
      checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("FAIL wrap_held_branch got=%b/%h exp=1/fffffffc", instr_req_o, instr_addr_o); end
      cyc(); drive(1, 0, 0, 1);
      @(negedge clk_i);
      checks++; if (instr_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got=%h exp=fffffffc", instr_addr_o); end
      cyc(); drive(1, 0, 0, 1); resp(32'hFFFF_FFFC, 1, 1);
      @(negedge clk_i);
      checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", instr_req_o, instr_addr_o); end
      cyc(); drive(0, 0, 0, 0); resp(32'h0, 1, 0);
      cyc();
   endtask

   task automatic test_fifo_busy();
      for (int i = 0; i < 4; i++) begin
         fifo_busy_i = (i < 2) ? 2'b11 : 2'b01;
         drive(1, 0, 0, 1);
         @(negedge clk_i);
         checks++; if (instr_req_o !== (i == 2)) begin errors++; $display("FAIL fbusy_c%0d got=%b exp=%b", i, instr_req_o, i == 2); end
         cyc();
      end
      fifo_busy_i = 2'b00; drive(0, 0, 0, 0); resp(32'h4, 1, 0); cyc();
      fifo_busy_i = 2'b11; drive(1, 1, 32'h40, 1);
      @(negedge clk_i);
      checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL fbusy_branch got=%b/%h exp=1/00000040", instr_req_o, instr_addr_o); end
      cyc(); fifo_busy_i = 2'b00; drive(0, 0, 0, 0); resp(32'h40, 1, 0);
      cyc();
   endtask

   task automatic test_async_reset();
      drive(1, 0, 0, 1); cyc();
      drive(1, 0, 0, 1); cyc();
      drive(0, 0, 0, 0);
      checks++; if ({busy_o, instr_addr_o} !== {1'b1, 32'h4C}) begin errors++; $display("FAIL ar_before got=%b/%h exp=1/0000004c", busy_o, instr_addr_o); end
      #2 rst_ni = 1'b0;
      #1;
      checks++; if ({instr_req_o, busy_o, fifo_valid_o, instr_addr_o} !== 35'h0) begin errors++; $display("FAIL ar_immediate got=%b%b%b/%h exp=000/00000000", instr_req_o, busy_o, fifo_valid_o, instr_addr_o); end
      checks++; if ({perf_req_cnt_o, perf_discard_cnt_o} !== 64'h0) begin errors++; $display("FAIL ar_perf got=%h/%h exp=0/0", perf_req_cnt_o, perf_discard_cnt_o); end
      cyc(); rst_ni = 1'b1;
      drive(1, 1, 32'h300, 1);
      @(negedge clk_i);
      checks++; if ({instr_req_o, instr_addr_o} !== {1'b1, 32'h300}) begin errors++; $display("FAIL ar_refetch got=%b/%h exp=1/00000300", instr_req_o, instr_addr_o); end
      cyc(); drive(0, 0, 0, 0); resp(32'h300, 1, 0);
      @(negedge clk_i);
`ifdef IBEX_FETCH_PERF_EN
      checks++; if (perf_req_cnt_o !== 32'd1) begin errors++; $display("FAIL ar_perf_after got=%0d exp=1", perf_req_cnt_o); end
`else
      checks++; if (perf_req_cnt_o !== 32'd0) begin errors++; $display("FAIL ar_perf_after got=%0d exp=0", perf_req_cnt_o); end
`endif
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk_i);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ar_idle got=%b exp=0", busy_o); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_limit();
      test_branch_discard();
      test_hold();
      test_wrap();
      test_fifo_busy();
      test_async_reset();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_writes got=%0d exp=0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
